// File: rtl/wavegen_pkg.sv
// Shared definitions for the DDS waveform generator: mode encodings, default
// widths and the elaboration-time sine table generator.
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } wave_mode_e;

  localparam int PHASE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 4;

  localparam real PI = 3.14159265358979323846;

  // Offset-binary sine, rounded. The second half is built as the complement of
  // the first so the table is exactly antisymmetric about mid-scale.
  function automatic int sine_sample(input int idx, input int addr_w, input int data_w);
    int  half;
    int  base;
    int  v;
    real amp;
    real ang;
    half = (1 << addr_w) / 2;
    base = idx % half;
    amp  = real'((1 << data_w) - 1) / 2.0;
    ang  = 2.0 * PI * real'(base) / real'(1 << addr_w);
    v    = $rtoi(amp + amp * $sin(ang) + 0.5);
    if (idx >= half) v = ((1 << data_w) - 1) - v;
    return v;
  endfunction

endpackage

// File: rtl/wave_sine_table.sv
// Combinational sine lookup; contents are fixed at elaboration.
module wave_sine_table
  import wavegen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] lut [2**ADDR_W];

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_lut
    localparam int V = sine_sample(i, ADDR_W, DATA_W);
    assign lut[i] = DATA_W'(V);
  end

  assign data = lut[addr];

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform generator: phase accumulator, config registers, waveform mux and
// a single-entry valid/ready output register.
module dds_wavegen
  import wavegen_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         mode,
  input  logic               phase_clr,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_wrap,
  output logic               out_valid,
  input  logic               out_ready
);

  function automatic logic [DATA_W-1:0] tri_fold(input logic [DATA_W:0] t);
    return t[DATA_W] ? ~t[DATA_W-1:0] : t[DATA_W-1:0];
  endfunction

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq_q;
  wave_mode_e         mode_q;
  logic               adv;
  logic [PHASE_W:0]   sum_p0;
  logic [DATA_W-1:0]  sine_p0;
  logic [DATA_W-1:0]  wave_p0;

  wave_sine_table #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sine (
    .addr(phase[PHASE_W-1 -: ADDR_W]),
    .data(sine_p0)
  );

  assign adv    = enable && (!out_valid || out_ready);
  assign sum_p0 = {1'b0, phase} + {1'b0, freq_q};

  // p0: waveform selection from the current phase
  always_comb begin
    wave_p0 = '0;
    case (mode_q)
      MODE_SINE:   wave_p0 = sine_p0;
      MODE_SQUARE: wave_p0 = phase[PHASE_W-1] ? '0 : '1;
      MODE_TRI:    wave_p0 = tri_fold(phase[PHASE_W-1 -: DATA_W+1]);
      MODE_SAW:    wave_p0 = phase[PHASE_W-1 -: DATA_W];
      default:     wave_p0 = '0;
    endcase
  end

  // p1: output register, accumulator and configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      freq_q    <= '0;
      mode_q    <= MODE_SINE;
      out_data  <= '0;
      out_wrap  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (cfg_load) begin
        freq_q <= freq_word;
        mode_q <= wave_mode_e'(mode);
      end
      if (adv) begin
        out_data  <= wave_p0;
        out_valid <= 1'b1;
        if (phase_clr) begin
          phase    <= '0;
          out_wrap <= 1'b0;
        end else begin
          phase    <= sum_p0[PHASE_W-1:0];
          out_wrap <= sum_p0[PHASE_W];
        end
      end else begin
        if (phase_clr) phase <= '0;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_wavegen.sv
// Directed bench for dds_wavegen with hand-computed expected samples.
module tb_dds_wavegen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_load;
  logic [15:0] freq_word;
  logic [1:0]  mode;
  logic        phase_clr;
  logic [3:0]  out_data;
  logic        out_wrap;
  logic        out_valid;
  logic        out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  int sine_ref [32] = '{8, 9, 10, 12, 13, 14, 14, 15, 15, 15, 14, 14, 13, 12, 10, 9,
                        7, 6, 5, 3, 2, 1, 1, 0, 0, 0, 1, 1, 2, 3, 5, 6};

  dds_wavegen #(.PHASE_W(16), .ADDR_W(5), .DATA_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .freq_word(freq_word), .mode(mode), .phase_clr(phase_clr),
    .out_data(out_data), .out_wrap(out_wrap), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sample(input string tag, input int data, input bit wrap);
    check({tag, "_valid"}, 8'(out_valid), 8'd1);
    check({tag, "_data"}, 8'(out_data), 8'(data));
    check({tag, "_wrap"}, 8'(out_wrap), 8'(wrap));
  endtask

  // Load config with no production in the same cycle, then enable.
  task automatic load_cfg(input logic [15:0] f, input logic [1:0] m, input bit clr);
    enable = 1'b0; cfg_load = 1'b1; freq_word = f; mode = m; phase_clr = clr;
    tick();
    cfg_load = 1'b0; phase_clr = 1'b0; enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; freq_word = '0;
    mode = 2'd0; phase_clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 8'(out_valid), 8'd0);
    check("rst_data", 8'(out_data), 8'd0);
    check("rst_wrap", 8'(out_wrap), 8'd0);
    reset = 1'b0;

    // Sine at one table step per sample, two periods
    load_cfg(16'h0800, 2'd0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      tick();
      sample("sine1", sine_ref[k % 32], (k % 32) == 31);
    end

    // Double-rate sine
    load_cfg(16'h1000, 2'd0, 1'b0);
    check("idle_valid", 8'(out_valid), 8'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      sample("sine2", sine_ref[(2 * k) % 32], (k % 16) == 15);
    end

    // Backpressure holds the sample and the phase
    load_cfg(16'h0800, 2'd0, 1'b0);
    tick();
    sample("bp_first", 8, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      sample("bp_hold", 8, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    sample("bp_release", 9, 1'b0);

    // Square, from a cleared phase
    load_cfg(16'h0800, 2'd1, 1'b1);
    for (int k = 0; k < 32; k++) begin
      tick();
      check("square", 8'(out_data), (k < 16) ? 8'hF : 8'h0);
    end

    // Triangle
    load_cfg(16'h0800, 2'd2, 1'b0);
    for (int k = 0; k < 32; k++) begin
      tick();
      check("triangle", 8'(out_data), (k < 16) ? 8'(k) : 8'(31 - k));
    end

    // Sawtooth
    load_cfg(16'h1000, 2'd3, 1'b0);
    for (int k = 0; k < 16; k++) begin
      tick();
      sample("saw", k, k == 15);
    end

    // Mode switch in a producing cycle
    load_cfg(16'h0800, 2'd0, 1'b0);
    tick();
    check("sw_first", 8'(out_data), 8'd8);
    cfg_load = 1'b1; mode = 2'd1;
    tick();
    cfg_load = 1'b0;
    check("sw_old_mode", 8'(out_data), 8'd9);
    tick();
    check("sw_new_mode", 8'(out_data), 8'hF);

    // Reset mid-stream, then freq 0 / sine defaults
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_valid", 8'(out_valid), 8'd0);
    check("rst2_data", 8'(out_data), 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      sample("freq0", 8, 1'b0);
    end

    // Single phase clear mid-stream
    cfg_load = 1'b1; freq_word = 16'h0800; mode = 2'd0;
    tick();
    cfg_load = 1'b0;
    check("clr_pre0", 8'(out_data), 8'd8);
    tick();
    check("clr_pre1", 8'(out_data), 8'd8);
    tick();
    check("clr_pre2", 8'(out_data), 8'd9);
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    sample("clr_taken", 10, 1'b0);
    tick();
    sample("clr_after", 8, 1'b0);

    // Pending sample survives enable low until accepted
    enable = 1'b0; out_ready = 1'b0;
    tick();
    sample("pend_hold", 8, 1'b0);
    out_ready = 1'b1;
    tick();
    check("pend_drain", 8'(out_valid), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
